// File: rtl/hfosc_seq.sv
// hfosc_seq: sequences powerup/enable of the high-frequency oscillator from the
// PMU's asynchronous fast-clock request. Runs on the always-on slow clock.
// Powerup leads enable by PU_SETTLE_CYCLES. Enable is dropped EN_DRAIN_CYCLES
// before powerup. Outputs decode only from the state register.
module hfosc_seq #(
    parameter int PU_SETTLE_CYCLES = 4,
    parameter int EN_DRAIN_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_req,
    output logic        clkhf_pu,
    output logic        clkhf_en,
    output logic        clk_ready,
    output logic        busy,
    output logic [15:0] wake_count
);

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        POWERUP = 2'd1,
        ON      = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [7:0] PU_LOAD = 8'(PU_SETTLE_CYCLES - 1);
    localparam logic [7:0] EN_LOAD = 8'(EN_DRAIN_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [15:0] wake_q, wake_nxt;
    logic        req_meta, req_s;

    // two-flop synchronizer for the asynchronous PMU request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= pwr_req;
            req_s    <= req_meta;
        end
    end

    // state, shared settle/drain counter and wake counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= OFF;
            cnt    <= 8'd0;
            wake_q <= 16'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            wake_q <= wake_nxt;
        end
    end

    // next-state: abort wins over settle completion; drain ignores the request
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wake_nxt  = wake_q;
        case (state)
            OFF: begin
                if (req_s) begin
                    state_nxt = POWERUP;
                    cnt_nxt   = PU_LOAD;
                end
            end
            POWERUP: begin
                if (!req_s) begin
                    state_nxt = OFF;
                    cnt_nxt   = 8'd0;
                end else if (cnt == 8'd0) begin
                    state_nxt = ON;
                    if (wake_q != 16'hFFFF) wake_nxt = wake_q + 16'd1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ON: begin
                if (!req_s) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = EN_LOAD;
                end
            end
            DRAIN: begin
                if (cnt == 8'd0) state_nxt = OFF;
                else             cnt_nxt   = cnt - 8'd1;
            end
            default: begin
                state_nxt = OFF;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // output decode from the registered state only
    always_comb begin
        clkhf_pu  = 1'b0;
        clkhf_en  = 1'b0;
        clk_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            POWERUP: begin clkhf_pu = 1'b1; busy = 1'b1; end
            ON:      begin clkhf_pu = 1'b1; clkhf_en = 1'b1; clk_ready = 1'b1; end
            DRAIN:   begin clkhf_pu = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    assign wake_count = wake_q;

endmodule

// File: tb/tb_hfosc_seq.sv
// Directed bench for hfosc_seq: power-up, drain, abort, re-request during
// drain, asynchronous reset mid-flight, wake counter saturation and a random
// request soak with ordering invariants checked every cycle.
module tb_hfosc_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwr_req = 1'b0;
    logic        clkhf_pu, clkhf_en, clk_ready, busy;
    logic [15:0] wake_count;

    int errors = 0;
    int checks = 0;

    hfosc_seq #(.PU_SETTLE_CYCLES(4), .EN_DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req),
        .clkhf_pu(clkhf_pu), .clkhf_en(clkhf_en), .clk_ready(clk_ready),
        .busy(busy), .wake_count(wake_count)
    );

    always #5 clk = ~clk;

    // sampling and driving both happen on the falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pwr_req = 1'b0;
        step(2);
        checks++; if ({clkhf_pu, clkhf_en, clk_ready, busy} !== 4'b0000)
            begin errors++; $display("FAIL reset_outs: got %b expected 0000", {clkhf_pu, clkhf_en, clk_ready, busy}); end
        checks++; if (wake_count !== 16'd0)
            begin errors++; $display("FAIL reset_wake: got %0h expected 0", wake_count); end
        rst_n = 1'b1;
        step(2);
        checks++; if (clkhf_pu !== 1'b0)
            begin errors++; $display("FAIL idle_pu: got %b expected 0", clkhf_pu); end
    endtask

    task automatic test_powerup();
        pwr_req = 1'b1;
        step(2);
        checks++; if (clkhf_pu !== 1'b0)
            begin errors++; $display("FAIL pu_early: got %b expected 0", clkhf_pu); end
        step(1);
        checks++; if ({clkhf_pu, clkhf_en, busy} !== 3'b101)
            begin errors++; $display("FAIL pu_rise: got %b expected 101", {clkhf_pu, clkhf_en, busy}); end
        for (int i = 1; i <= 3; i++) begin
            step(1);
            checks++; if ({clkhf_en, clk_ready, busy} !== 3'b001)
                begin errors++; $display("FAIL settle_%0d: got %b expected 001", i, {clkhf_en, clk_ready, busy}); end
        end
        step(1);
        checks++; if ({clkhf_pu, clkhf_en, clk_ready, busy} !== 4'b1110)
            begin errors++; $display("FAIL on_entry: got %b expected 1110", {clkhf_pu, clkhf_en, clk_ready, busy}); end
        checks++; if (wake_count !== 16'd1)
            begin errors++; $display("FAIL wake_first: got %0h expected 1", wake_count); end
    endtask

    task automatic test_drain();
        pwr_req = 1'b0;
        step(2);
        checks++; if (clkhf_en !== 1'b1)
            begin errors++; $display("FAIL en_hold: got %b expected 1", clkhf_en); end
        step(1);
        checks++; if ({clkhf_pu, clkhf_en, clk_ready, busy} !== 4'b1001)
            begin errors++; $display("FAIL drain_entry: got %b expected 1001", {clkhf_pu, clkhf_en, clk_ready, busy}); end
        step(1);
        checks++; if (clkhf_pu !== 1'b1)
            begin errors++; $display("FAIL drain_pu: got %b expected 1", clkhf_pu); end
        step(1);
        checks++; if ({clkhf_pu, busy} !== 2'b00)
            begin errors++; $display("FAIL drain_done: got %b expected 00", {clkhf_pu, busy}); end
        checks++; if (wake_count !== 16'd1)
            begin errors++; $display("FAIL wake_drain: got %0h expected 1", wake_count); end
    endtask

    task automatic test_abort();
        pwr_req = 1'b1;
        step(3);
        checks++; if ({clkhf_pu, clkhf_en} !== 2'b10)
            begin errors++; $display("FAIL abort_pu: got %b expected 10", {clkhf_pu, clkhf_en}); end
        step(1);
        pwr_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if ({clkhf_en, clk_ready} !== 2'b00)
                begin errors++; $display("FAIL abort_en_%0d: got %b expected 00", i, {clkhf_en, clk_ready}); end
        end
        checks++; if ({clkhf_pu, busy} !== 2'b00)
            begin errors++; $display("FAIL abort_off: got %b expected 00", {clkhf_pu, busy}); end
        checks++; if (wake_count !== 16'd1)
            begin errors++; $display("FAIL abort_wake: got %0h expected 1", wake_count); end
    endtask

    task automatic test_back_to_back();
        pwr_req = 1'b1;
        step(7);
        checks++; if ({clk_ready, wake_count} !== {1'b1, 16'd2})
            begin errors++; $display("FAIL b2b_on: got %b/%0h expected 1/2", clk_ready, wake_count); end
        pwr_req = 1'b0;
        step(3);
        checks++; if ({clkhf_pu, clkhf_en, busy} !== 3'b101)
            begin errors++; $display("FAIL b2b_drain: got %b expected 101", {clkhf_pu, clkhf_en, busy}); end
        pwr_req = 1'b1;
        step(1);
        checks++; if (clkhf_pu !== 1'b1)
            begin errors++; $display("FAIL b2b_drain_pu: got %b expected 1", clkhf_pu); end
        step(1);
        checks++; if ({clkhf_pu, busy} !== 2'b00)
            begin errors++; $display("FAIL b2b_off_gap: got %b expected 00", {clkhf_pu, busy}); end
        step(1);
        checks++; if ({clkhf_pu, clkhf_en, busy} !== 3'b101)
            begin errors++; $display("FAIL b2b_repower: got %b expected 101", {clkhf_pu, clkhf_en, busy}); end
        step(3);
        checks++; if (clkhf_en !== 1'b0)
            begin errors++; $display("FAIL b2b_settle: got %b expected 0", clkhf_en); end
        step(1);
        checks++; if ({clkhf_en, clk_ready, wake_count} !== {2'b11, 16'd3})
            begin errors++; $display("FAIL b2b_on2: got %b/%0h expected 11/3", {clkhf_en, clk_ready}, wake_count); end
    endtask

    // enters with req=1 and state ON; reset is applied off the clock edge
    task automatic test_async_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({clkhf_pu, clkhf_en, clk_ready, busy, wake_count} !== 20'd0)
            begin errors++; $display("FAIL arst_on: got %b/%0h expected 0000/0", {clkhf_pu, clkhf_en, clk_ready, busy}, wake_count); end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rst_n = 1'b1;
            step(2);
            checks++; if (clkhf_pu !== 1'b0)
                begin errors++; $display("FAIL rec%0d_pu_early: got %b expected 0", k, clkhf_pu); end
            step(1);
            checks++; if ({clkhf_pu, busy} !== 2'b11)
                begin errors++; $display("FAIL rec%0d_pu: got %b expected 11", k, {clkhf_pu, busy}); end
            if (k == 0) begin
                step(1);
                #1 rst_n = 1'b0;
                #1;
                checks++; if ({clkhf_pu, clkhf_en, clk_ready, busy, wake_count} !== 20'd0)
                    begin errors++; $display("FAIL arst_powerup: got %b/%0h expected 0000/0", {clkhf_pu, clkhf_en, clk_ready, busy}, wake_count); end
                @(negedge clk);
            end else begin
                step(3);
                checks++; if (clkhf_en !== 1'b0)
                    begin errors++; $display("FAIL rec%0d_settle: got %b expected 0", k, clkhf_en); end
                step(1);
                checks++; if ({clkhf_en, clk_ready, wake_count} !== {2'b11, 16'd1})
                    begin errors++; $display("FAIL rec%0d_on: got %b/%0h expected 11/1", k, {clkhf_en, clk_ready}, wake_count); end
                if (k == 1) begin
                    #1 rst_n = 1'b0;
                    #1;
                    checks++; if ({clkhf_pu, clkhf_en, clk_ready, busy, wake_count} !== 20'd0)
                        begin errors++; $display("FAIL arst_on2: got %b/%0h expected 0000/0", {clkhf_pu, clkhf_en, clk_ready, busy}, wake_count); end
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int n;
        pwr_req = 1'b0;
        step(6);
        checks++; if ({clkhf_pu, busy} !== 2'b00)
            begin errors++; $display("FAIL sat_off: got %b expected 00", {clkhf_pu, busy}); end
        force dut.wake_q = 16'hFFFE;
        #1 release dut.wake_q;
        #1;
        checks++; if (wake_count !== 16'hFFFE)
            begin errors++; $display("FAIL sat_preload: got %0h expected fffe", wake_count); end
        for (int s = 0; s < 3; s++) begin
            pwr_req = 1'b1;
            n = 0;
            while (clk_ready !== 1'b1 && n < 20) begin step(1); n++; end
            checks++; if (clk_ready !== 1'b1)
                begin errors++; $display("FAIL sat_ready_timeout_%0d: got %b expected 1", s, clk_ready); end
            checks++; if (wake_count !== 16'hFFFF)
                begin errors++; $display("FAIL sat_wake_%0d: got %0h expected ffff", s, wake_count); end
            pwr_req = 1'b0;
            n = 0;
            while ((clkhf_pu !== 1'b0 || busy !== 1'b0) && n < 20) begin step(1); n++; end
            checks++; if ({clkhf_pu, busy} !== 2'b00)
                begin errors++; $display("FAIL sat_off_timeout_%0d: got %b expected 00", s, {clkhf_pu, busy}); end
        end
    endtask

    task automatic test_random();
        logic prev_pu, prev_en;
        @(negedge clk);
        prev_pu = clkhf_pu;
        prev_en = clkhf_en;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) pwr_req = ~pwr_req;
            step(1);
            checks++; if (clkhf_en && !clkhf_pu)
                begin errors++; $display("FAIL rnd_en_pu c%0d: got en=1 pu=0 expected pu=1", c); end
            checks++; if (clk_ready !== clkhf_en || busy !== (clkhf_pu && !clkhf_en))
                begin errors++; $display("FAIL rnd_decode c%0d: got ready=%b busy=%b expected ready=%b busy=%b", c, clk_ready, busy, clkhf_en, clkhf_pu && !clkhf_en); end
            checks++; if (prev_en && !clkhf_en && prev_pu && !clkhf_pu)
                begin errors++; $display("FAIL rnd_fall c%0d: got pu,en falling together expected pu held", c); end
            prev_pu = clkhf_pu;
            prev_en = clkhf_en;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_powerup();
        test_drain();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
